hb_io_bank: RTL and testbench

Parametrised memory-mapped I/O bank for the Hummingbird CPU. It replaces the fixed three-output, one-input device decode with NUM_OUT handshaked output channels and one buffered input channel. The input channel is fed by an IN_DEPTH-entry FIFO and reports status flags. It sits behind the CPU's I/O chip-select (address page 0xFFx) and shares the 8-bit data bus.

---
 rtl/hb_io_pkg.sv | 16 +
 rtl/hb_sync_fifo.sv | 79 +++++++
 rtl/hb_io_bank.sv | 120 ++++++++++++
 tb/tb_hb_io_bank.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hb_io_pkg.sv
// Shared register map and bit positions for the Hummingbird I/O bank.
package hb_io_pkg;

    localparam logic [3:0] IO_STATUS  = 4'hC;
    localparam logic [3:0] IO_IN_DATA = 4'hD;
    localparam logic [3:0] IO_CTRL    = 4'hE;

    localparam int ST_NONEMPTY  = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERFLOW  = 2;
    localparam int ST_VALID_LSB = 4;

    localparam int CTRL_CLR_OVF = 0;
    localparam int CTRL_FLUSH   = 1;

endpackage

// File: rtl/hb_sync_fifo.sv
// Single-clock FIFO with flush. A push into a full FIFO is accepted only
// when a pop frees the head slot in the same cycle; otherwise it is dropped.
module hb_sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                         clk,
    input  logic                         rst_bar,
    input  logic                         push,
    input  logic [DATA_W-1:0]            wdata,
    input  logic                         pop,
    input  logic                         flush,
    output logic [DATA_W-1:0]            rdata,
    output logic                         full,
    output logic                         empty,
    output logic                         drop,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign drop    = push && full && !pop_ok;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Storage needs no reset: words beyond count are never presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/hb_io_bank.sv
// Memory-mapped I/O bank: NUM_OUT handshaked output registers plus one
// FIFO-buffered input channel with status and control registers.
module hb_io_bank
    import hb_io_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int NUM_OUT  = 3,
    parameter int IN_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst_bar,
    input  logic                      io_sel,
    input  logic                      io_we,
    input  logic [3:0]                io_addr,
    input  logic [DATA_W-1:0]         io_wdata,
    output logic [DATA_W-1:0]         io_rdata,
    output logic [NUM_OUT*DATA_W-1:0] out_data,
    output logic [NUM_OUT-1:0]        out_valid,
    input  logic [NUM_OUT-1:0]        out_ack,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_valid,
    output logic                      in_ready
);
    localparam int CNT_W = $clog2(IN_DEPTH + 1);

    logic [NUM_OUT-1:0][DATA_W-1:0] out_data_q, out_data_d;
    logic [NUM_OUT-1:0]             out_valid_q, out_valid_d;
    logic                           ovf_q, ovf_d;

    logic              rd_en, wr_en, ctrl_wr, clr_ovf, flush, pop_req;
    logic [DATA_W-1:0] fifo_rdata, status;
    logic              fifo_full, fifo_empty, fifo_drop;
    logic [CNT_W-1:0]  fifo_count;

    assign rd_en   = io_sel && !io_we;
    assign wr_en   = io_sel && io_we;
    assign ctrl_wr = wr_en && (io_addr == IO_CTRL);
    assign clr_ovf = ctrl_wr && io_wdata[CTRL_CLR_OVF];
    assign flush   = ctrl_wr && io_wdata[CTRL_FLUSH];
    assign pop_req = rd_en && (io_addr == IO_IN_DATA);

    hb_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (IN_DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst_bar (rst_bar),
        .push  (in_valid),
        .wdata (in_data),
        .pop   (pop_req),
        .flush (flush),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop),
        .count (fifo_count)
    );

    assign in_ready  = (fifo_count != CNT_W'(IN_DEPTH));
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

    always_comb begin
        status               = '0;
        status[ST_NONEMPTY]  = !fifo_empty;
        status[ST_FULL]      = fifo_full;
        status[ST_OVERFLOW]  = ovf_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            status[ST_VALID_LSB + i] = out_valid_q[i];
        end
    end

    always_comb begin
        io_rdata = '0;
        if (rd_en) begin
            if (io_addr == IO_STATUS) begin
                io_rdata = status;
            end else if (io_addr == IO_IN_DATA) begin
                io_rdata = fifo_empty ? '0 : fifo_rdata;
            end else begin
                for (int i = 0; i < NUM_OUT; i++) begin
                    if (io_addr == 4'(i)) io_rdata = out_data_q[i];
                end
            end
        end
    end

    // A CPU write beats a same-cycle ack: the ack consumed the old word.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        for (int i = 0; i < NUM_OUT; i++) begin
            if (wr_en && (io_addr == 4'(i))) begin
                out_data_d[i]  = io_wdata;
                out_valid_d[i] = 1'b1;
            end else if (out_ack[i]) begin
                out_valid_d[i] = 1'b0;
            end
        end
    end

    always_comb begin
        ovf_d = ovf_q;
        if (clr_ovf)   ovf_d = 1'b0;
        if (fifo_drop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            out_data_q  <= '0;
            out_valid_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
        end
    end

endmodule

// File: tb/tb_hb_io_bank.sv
// Scoreboard bench for hb_io_bank: a queue/array reference model predicts
// every read and the per-cycle output state; a negedge monitor compares.
module tb_hb_io_bank;
    localparam int DW  = 8;
    localparam int NO  = 3;
    localparam int DEP = 4;

    logic            clk = 1'b0;
    logic            rst_bar = 1'b0;
    logic            io_sel = 1'b0;
    logic            io_we = 1'b0;
    logic [3:0]      io_addr = '0;
    logic [DW-1:0]   io_wdata = '0;
    logic [DW-1:0]   io_rdata;
    logic [NO*DW-1:0] out_data;
    logic [NO-1:0]   out_valid;
    logic [NO-1:0]   out_ack = '0;
    logic [DW-1:0]   in_data = '0;
    logic            in_valid = 1'b0;
    logic            in_ready;

    hb_io_bank #(.DATA_W(DW), .NUM_OUT(NO), .IN_DEPTH(DEP)) dut (
        .clk       (clk),
        .rst_bar   (rst_bar),
        .io_sel    (io_sel),
        .io_we     (io_we),
        .io_addr   (io_addr),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [NO-1:0]    v;
        logic [NO*DW-1:0] d;
        logic             rdy;
    } snap_t;

    snap_t         st_q[$];
    logic [DW-1:0] rd_q[$];
    snap_t         mon_s;

    // Reference model
    logic [DW-1:0] m_data [NO];
    logic [NO-1:0] m_valid;
    logic [DW-1:0] m_fifo[$];
    logic          m_ovf;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NO; i++) m_data[i] = '0;
        m_valid = '0;
        m_fifo.delete();
        m_ovf = 1'b0;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [3:0] a);
        logic [DW-1:0] s;
        s = '0;
        if (a < NO) return m_data[a];
        if (a == 4'hD) return (m_fifo.size() != 0) ? m_fifo[0] : '0;
        if (a == 4'hC) begin
            s[0] = (m_fifo.size() != 0);
            s[1] = (m_fifo.size() == DEP);
            s[2] = m_ovf;
            for (int i = 0; i < NO; i++) s[4+i] = m_valid[i];
            return s;
        end
        return '0;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.v = m_valid;
        for (int i = 0; i < NO; i++) s.d[i*DW +: DW] = m_data[i];
        s.rdy = (m_fifo.size() != DEP);
        return s;
    endfunction

    task automatic model_step(input logic sel, input logic we, input logic [3:0] a,
                              input logic [DW-1:0] wd, input logic [NO-1:0] ack,
                              input logic iv, input logic [DW-1:0] id);
        bit was_full, do_pop, do_flush, do_clr;
        was_full = (m_fifo.size() == DEP);
        do_pop   = sel && !we && (a == 4'hD) && (m_fifo.size() != 0);
        do_flush = sel && we && (a == 4'hE) && wd[1];
        do_clr   = sel && we && (a == 4'hE) && wd[0];
        if (do_pop) void'(m_fifo.pop_front());
        if (iv && (!was_full || do_pop)) m_fifo.push_back(id);
        if (do_flush) m_fifo.delete();
        if (do_clr) m_ovf = 1'b0;
        if (iv && was_full && !do_pop) m_ovf = 1'b1;
        for (int i = 0; i < NO; i++) begin
            if (sel && we && (a == 4'(i))) begin
                m_data[i]  = wd;
                m_valid[i] = 1'b1;
            end else if (ack[i]) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    // One bus cycle; exp_rd >= 0 overrides the model's read prediction with a fixed value.
    task automatic cycle(input logic sel, input logic we, input logic [3:0] a,
                         input logic [DW-1:0] wd, input logic [NO-1:0] ack,
                         input logic iv, input logic [DW-1:0] id, input int exp_rd = -1);
        @(posedge clk);
        #1;
        io_sel = sel; io_we = we; io_addr = a; io_wdata = wd;
        out_ack = ack; in_valid = iv; in_data = id;
        if (sel && !we) rd_q.push_back((exp_rd >= 0) ? DW'(exp_rd) : model_read(a));
        st_q.push_back(model_snap());
        model_step(sel, we, a, wd, ack, iv, id);
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 4'h0, 8'h00, '0, 1'b0, 8'h00);
    endtask

    task automatic wr(input logic [3:0] a, input logic [DW-1:0] d);
        cycle(1'b1, 1'b1, a, d, '0, 1'b0, 8'h00);
    endtask

    task automatic rd(input logic [3:0] a, input int exp);
        cycle(1'b1, 1'b0, a, 8'h00, '0, 1'b0, 8'h00, exp);
    endtask

    task automatic push(input logic [DW-1:0] d);
        cycle(1'b0, 1'b0, 4'h0, 8'h00, '0, 1'b1, d);
    endtask

    always @(negedge clk) begin
        if (rst_bar) begin
            if (st_q.size() > 0) begin
                mon_s = st_q.pop_front();
                check("out_valid", 32'(out_valid), 32'(mon_s.v));
                check("out_data", 32'(out_data), 32'(mon_s.d));
                check("in_ready", 32'(in_ready), 32'(mon_s.rdy));
            end
            if (io_sel && !io_we) begin
                if (rd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL io_rdata_unexpected: actual=%0h required=none", io_rdata);
                end else begin
                    check($sformatf("io_rdata@%0h", io_addr), 32'(io_rdata), 32'(rd_q.pop_front()));
                end
            end
        end
    end

    initial begin
        logic [3:0]    a;
        logic [DW-1:0] wd;
        int            r;

        model_reset();
        io_sel = 1'b1; io_we = 1'b0; io_addr = 4'hC;
        #12;
        check("reset_out_valid", 32'(out_valid), 32'h0);
        check("reset_out_data", 32'(out_data), 32'h0);
        check("reset_status", 32'(io_rdata), 32'h0);
        check("reset_in_ready", 32'(in_ready), 32'h1);
        io_sel = 1'b0;
        @(negedge clk);
        rst_bar = 1'b1;
        idle();

        // Output handshake
        wr(4'h1, 8'h5A);
        rd(4'hC, 8'h20);
        rd(4'h1, 8'h5A);
        cycle(1'b0, 1'b0, 4'h0, 8'h00, 3'b010, 1'b0, 8'h00);
        rd(4'hC, 8'h00);

        // Write/ack collision on channel 0
        wr(4'h0, 8'h11);
        cycle(1'b1, 1'b1, 4'h0, 8'h22, 3'b001, 1'b0, 8'h00);
        rd(4'h0, 8'h22);
        rd(4'hC, 8'h10);
        cycle(1'b0, 1'b0, 4'h0, 8'h00, 3'b001, 1'b0, 8'h00);
        cycle(1'b0, 1'b0, 4'h0, 8'h00, 3'b100, 1'b0, 8'h00);
        wr(4'h2, 8'h33);
        wr(4'h2, 8'h44);
        rd(4'hC, 8'h40);
        rd(4'h2, 8'h44);
        rd(4'h7, 8'h00);

        // Fill and overflow
        for (int k = 1; k <= 5; k++) push(8'(k));
        rd(4'hC, 8'h47);
        for (int k = 1; k <= 4; k++) rd(4'hD, k);
        rd(4'hD, 8'h00);
        rd(4'hC, 8'h44);
        wr(4'hE, 8'h01);
        rd(4'hC, 8'h40);
        cycle(1'b0, 1'b0, 4'h0, 8'h00, 3'b100, 1'b0, 8'h00);

        // Full FIFO with simultaneous push and pop
        for (int k = 0; k < 4; k++) push(8'hA0 + 8'(k));
        cycle(1'b1, 1'b0, 4'hD, 8'h00, '0, 1'b1, 8'hA4, 8'hA0);
        rd(4'hC, 8'h03);
        for (int k = 1; k <= 4; k++) rd(4'hD, 8'hA0 + k);

        // Empty FIFO with simultaneous push and pop
        cycle(1'b1, 1'b0, 4'hD, 8'h00, '0, 1'b1, 8'h5C, 8'h00);
        rd(4'hC, 8'h01);
        rd(4'hD, 8'h5C);

        // CTRL flush + overflow clear with a same-cycle push
        for (int k = 0; k < 5; k++) push(8'hB0 + 8'(k));
        rd(4'hD, 8'hB0);
        rd(4'hD, 8'hB1);
        rd(4'hC, 8'h05);
        cycle(1'b1, 1'b1, 4'hE, 8'h03, '0, 1'b1, 8'hCC);
        rd(4'hC, 8'h00);
        rd(4'hD, 8'h00);

        // Reset in the middle of activity
        wr(4'h2, 8'h77);
        push(8'h99);
        idle();
        @(negedge clk);
        #2;
        rst_bar = 1'b0;
        io_sel = 1'b1; io_we = 1'b0; io_addr = 4'hC; in_valid = 1'b0; out_ack = '0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'h0);
        check("midreset_out_data", 32'(out_data), 32'h0);
        check("midreset_status", 32'(io_rdata), 32'h0);
        check("midreset_in_ready", 32'(in_ready), 32'h1);
        io_sel = 1'b0;
        st_q.delete();
        rd_q.delete();
        model_reset();
        @(negedge clk);
        rst_bar = 1'b1;
        idle();
        rd(4'hD, 8'h00);

        // Randomised traffic
        for (int n = 0; n < 800; n++) begin
            r  = $urandom_range(0, 99);
            wd = 8'($urandom);
            if (r < 28) begin
                a = 4'($urandom_range(0, NO - 1));
                cycle(1'b1, 1'b1, a, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end else if (r < 42) begin
                a = 4'($urandom_range(0, 15));
                cycle(1'b1, 1'b0, a, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end else if (r < 64) begin
                cycle(1'b1, 1'b0, 4'hD, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end else if (r < 74) begin
                cycle(1'b1, 1'b0, 4'hC, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end else if (r < 77) begin
                cycle(1'b1, 1'b1, 4'hE, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end else if (r < 81) begin
                a = 4'($urandom_range(3, 13));
                cycle(1'b1, 1'b1, a, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end else begin
                cycle(1'b0, 1'b0, 4'h0, wd, 3'($urandom), $urandom_range(0, 99) < 55, 8'($urandom));
            end
        end

        idle();
        repeat (2) @(negedge clk);
        #1;
        n_cmp++;
        if (st_q.size() != 0 || rd_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: actual=%0d/%0d required=0/0", st_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
